// File: rtl/fetch_queue_if.sv
// Icache request/response and decode dequeue signals of the fetch front end.
// master = fetch_queue side, slave = icache/decode side.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            icache_read;
    logic [XLEN-1:0] icache_addr;
    logic [XLEN-1:0] icache_rdata;
    logic            icache_resp;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            deq_ready;
    logic            deq_valid;
    logic [XLEN-1:0] deq_pc;
    logic [XLEN-1:0] deq_instr;
    logic [CW-1:0]   occupancy;

    modport master (
        output icache_read, icache_addr, deq_valid, deq_pc, deq_instr, occupancy,
        input  icache_rdata, icache_resp, redirect, redirect_pc, deq_ready
    );

    modport slave (
        input  icache_read, icache_addr, deq_valid, deq_pc, deq_instr, occupancy,
        output icache_rdata, icache_resp, redirect, redirect_pc, deq_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, runs a single-outstanding icache
// handshake and buffers {pc, instr} pairs in a DEPTH-entry FIFO drained by decode.
module fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0060
) (
    input  logic            clk,
    input  logic            rst,
    fetch_queue_if.master   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, SQUASH} state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          mem_q [DEPTH];

    logic            read, resp, enq, deq;
    logic [XLEN-1:0] addr, redir_pc;

    // A request only starts with a free slot; count can only fall while it is
    // outstanding, so the response always finds room.
    assign read     = rst & ((state_q != IDLE) | ((count_q < CW'(DEPTH)) & ~bus.redirect));
    assign addr     = (state_q == IDLE) ? fetch_pc_q : req_addr_q;
    assign resp     = read & bus.icache_resp;
    assign redir_pc = bus.redirect_pc & ~XLEN'(3);
    assign deq      = bus.deq_valid & bus.deq_ready;

    assign bus.icache_read = read;
    assign bus.icache_addr = addr;
    assign bus.deq_valid   = (count_q != '0) & ~bus.redirect;
    assign bus.deq_pc      = mem_q[rd_ptr_q].pc;
    assign bus.deq_instr   = mem_q[rd_ptr_q].instr;
    assign bus.occupancy   = count_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        enq        = 1'b0;
        if (bus.redirect) begin
            // A response coinciding with the redirect retires the request outright;
            // one still pending must be swallowed later in SQUASH.
            fetch_pc_d = redir_pc;
            if (resp)
                state_d = IDLE;
            else if (state_q == REQ)
                state_d = SQUASH;
        end else begin
            case (state_q)
                IDLE: begin
                    if (resp) begin
                        enq        = 1'b1;
                        fetch_pc_d = addr + XLEN'(4);
                    end else if (read) begin
                        req_addr_d = fetch_pc_q;
                        state_d    = REQ;
                    end
                end
                REQ: begin
                    if (resp) begin
                        enq        = 1'b1;
                        fetch_pc_d = addr + XLEN'(4);
                        state_d    = IDLE;
                    end
                end
                SQUASH:  if (resp) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(deq);
        wr_ptr_d = wr_ptr_q + AW'(enq);
        count_d  = count_q + CW'(enq) - CW'(deq);
        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (enq) begin
            mem_q[wr_ptr_q] <= '{pc: addr, instr: bus.icache_rdata};
        end
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the RV32I pipeline. It owns the fetch PC, runs a blocking single-outstanding handshake with the icache, and buffers fetched {pc, instruction} pairs in a DEPTH-entry FIFO. The decode stage drains the FIFO. A redirect from branch/jump resolution flushes the FIFO and restarts fetch, and squashes any in-flight icache response. This decouples icache latency from the IF/ID load/stall logic.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- XLEN, 32, address/instruction width
- RESET_PC, 32'h0000_0060, first fetch address after reset
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- icache_read  out  1  fetch request; held until icache_resp
- icache_addr  out  XLEN  fetch address; stable while icache_read=1 and no resp
- icache_rdata  in  XLEN  instruction word; valid with icache_resp
- icache_resp  in  1  one-cycle completion pulse; sampled only while icache_read=1
- redirect  in  1  taken branch/jal/jalr resolved in MEM; flush and refetch
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0)
- deq_ready  in  1  decode accepts head entry (IF/ID load)
- deq_valid  out  1  head entry present
- deq_pc  out  XLEN  PC of head entry
- deq_instr  out  XLEN  instruction of head entry
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count

## Operation
- State: fetch_pc, req_addr, FIFO (rd/wr pointers, count), FSM {IDLE, REQ, SQUASH}.
- icache_read = rst & ((state≠IDLE) | (count<DEPTH & ~redirect)).
- icache_addr = fetch_pc in IDLE, else req_addr.
- IDLE, read asserted, no resp: req_addr←fetch_pc; →REQ.
- IDLE or REQ, resp=1, no redirect:
  - enqueue {icache_addr, icache_rdata};
  - fetch_pc←icache_addr+4;
  - →IDLE.
- REQ, redirect, no resp: →SQUASH. The pending response is later discarded. fetch_pc←redirect_pc.
- Any state, redirect and resp in the same cycle: discard data; fetch_pc←redirect_pc; →IDLE.
- SQUASH, resp=1: drop data, no enqueue; →IDLE. SQUASH, redirect again: fetch_pc←new redirect_pc; stay in SQUASH.
- IDLE, redirect: fetch_pc←redirect_pc. No request is issued that cycle.
- Redirect, any state: count←0 and pointers←0 next edge. Same-cycle enqueue and dequeue are suppressed.
- Dequeue when deq_valid & deq_ready: rd_ptr++.
- deq_valid = (count≠0) & ~redirect.
- deq_pc/deq_instr are the head entry contents. Their value is don't-care when deq_valid=0.
- Enqueue and dequeue in the same cycle: count unchanged, both pointers advance. This is legal at count=DEPTH only if the dequeue is requested; an enqueue can never reach a full FIFO.
- Space reservation: a request starts only when count<DEPTH. While it is pending, count can only fall, so the response always has room.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. fetch_pc+4 wraps modulo 2^XLEN.
- No overflow or underflow is possible by construction. Dequeue with deq_valid=0 is ignored.

## Timing
- Reset (rst=0, async) values:
  - icache_read=0;
  - state=IDLE, fetch_pc=RESET_PC, req_addr=0;
  - count=0, pointers=0, all FIFO storage=0;
  - deq_valid=0, deq_pc=0, deq_instr=0, occupancy=0.
- First cycle after rst release: icache_read=1, icache_addr=RESET_PC.
- Latency: icache_resp at edge N → deq_valid=1 after edge N. There is no same-cycle bypass from icache_rdata to deq_*.
- Zero-wait cache (resp in the same cycle as read rising): supported; enqueued at that edge.
- Throughput: one instruction per cycle with a zero-wait cache and deq_ready=1.
- A new request may begin in the cycle after a resp (IDLE re-evaluated).
- Redirect takes effect at the next edge.
  - Fetch from redirect_pc starts the cycle after redirect if there is no pending request.
  - Otherwise it starts the cycle after the squashed resp.
- Reset asserted mid-request: the request is abandoned immediately (icache_read=0). Any late resp is ignored because it is only sampled while icache_read=1.

## Test plan
- Reset release, zero-wait icache returning addr-derived data, deq_ready=1 → icache_addr sequence 0x60, 0x64, 0x68…; deq_pc follows one cycle behind; occupancy never exceeds 1.
- deq_ready=0, 3-cycle icache latency, DEPTH=4 → exactly 4 entries enqueued (0x60–0x6C); icache_read=0 while occupancy=4. Then deq_ready=1 → entries drain in order and fetch resumes at 0x70.
- Redirect to 0x200 while a request for 0x68 is pending (SQUASH) → the 0x68 response is never dequeued; occupancy=0 next cycle; next icache_addr=0x200; first deq_pc=0x200.
- Redirect and resp in the same cycle, redirect_pc=0x1003 → data dropped; next fetch address is 0x1000.
- Two redirects (0x300, then 0x400) during one pending request → first post-squash fetch is 0x400; 0x300 is never fetched.
- rst driven low mid-request with count=2 → icache_read, deq_valid, occupancy go to 0 asynchronously; after release the fetch restarts at 0x60.
